freq_meter: RTL and testbench
=============================

# freq_meter

Single-clock period and high-time meter for a slow periodic signal, such as the output of a clock divider or any other low-rate strobe. It synchronises `sig_in`, detects its rising and falling edges, and counts `clk` cycles. It reports each period and high time with a one-cycle valid pulse. It sits directly downstream of the frequency dividers and serves as their on-chip checker and as a general-purpose tachometer.

## Interface
- `CNT_W`, 16, width of the period and high-time counters and results
- `SYNC_STAGES`, 2, synchroniser depth for `sig_in` (minimum 2)
- `clk`  input  1  sole clock; all logic is on the rising edge
- `rst`  input  1  synchronous, active-high reset
- `en`  input  1  measurement enable; low forces IDLE
- `sig_in`  input  1  measured signal, asynchronous to `clk`
- `period`  output  CNT_W  `clk` cycles between the last two rising edges
- `high_time`  output  CNT_W  `clk` cycles `sig_in` was high in that period
- `meas_valid`  output  1  one-cycle pulse when `period` and `high_time` update
- `overflow`  output  1  a counter saturated in the reported measurement; updates with `meas_valid`

## Operation
- `sig_in` passes through a `SYNC_STAGES` flop chain, giving `s`, then one delay flop, giving `s_d`.
  - `rise` = `s & ~s_d`; `fall` = `~s & s_d`.
- FSM states are IDLE, ARM and MEASURE.
  - IDLE: counters are cleared. Go to ARM when `en` = 1.
  - ARM: wait for `rise`, then load `pcnt` = 1 and `hcnt` = 1, clear `sat`, and go to MEASURE. If the signal is already high at enable, the meter waits for the next `rise`.
  - MEASURE, each cycle without `rise`:
    - `pcnt`++.
    - `hcnt`++ while `s` = 1 and no `fall` has occurred since the last `rise`.
    - `hcnt` freezes after `fall`.
  - MEASURE on `rise`:
    - Register `period` ← `pcnt`, `high_time` ← `hcnt` and `overflow` ← `sat`.
    - Pulse `meas_valid`.
    - Reload `pcnt` = `hcnt` = 1, clear `sat`, and stay in MEASURE.
- Saturation: `pcnt` and `hcnt` stop at 2^CNT_W−1 and set `sat`. They never wrap.
- `en` = 0 in any state: go to IDLE on the next edge and discard the partial measurement.
  - Outputs hold their last values; `meas_valid` = 0.
- `rise` and `en` falling in the same cycle: `en` wins. No report is made.
- A high or low pulse shorter than one `clk` period may be lost. This is not an error.
- A constant `sig_in` produces no `meas_valid`. Counters saturate, and `overflow` is reported at the next `rise`.

## Timing
- Reset values:
  - `period` = 0, `high_time` = 0, `meas_valid` = 0, `overflow` = 0.
  - FSM = IDLE; synchroniser and delay flops = 0.
- Latency: `meas_valid` rises `SYNC_STAGES`+2 clock edges after the first edge that samples `sig_in` high. That is 4 edges for the default.
- `period`, `high_time` and `overflow` are registered. They are valid in the same cycle as `meas_valid` and stable until the next pulse.
- Steady state: consecutive `meas_valid` pulses are exactly `period` cycles apart.
- Reset mid-measurement: synchronous clear to reset values on the next edge. No pulse is emitted.

## Structure
- Shared package:
  - FSM state enum (IDLE, ARM, MEASURE).
  - Default `CNT_W` and `SYNC_STAGES` constants.
- Sub-module `sync_edge_det`: `SYNC_STAGES` synchroniser plus delay flop. Outputs `s`, `rise` and `fall`; reset is synchronous to 0.
- Top level holds the FSM, the two saturating counters and the output registers.

## Test plan
- `sig_in` repeating 1,0,0 (one `clk` cycle per value), `en` = 1.
  - After the second rise: `period` = 3, `high_time` = 1, `overflow` = 0.
  - `meas_valid` every 3 cycles.
- `sig_in` high 5, low 7, repeated.
  - Each report: `period` = 12, `high_time` = 5.
  - First `meas_valid` exactly 4 edges after the second rising sample.
- `CNT_W` = 4, `sig_in` high 2, low 20.
  - `period` = 15, `high_time` = 2, `overflow` = 1.
  - The next normal period reports `overflow` = 0.
- `sig_in` held high when `en` rises, then falls after 10 cycles and pulses with period 6.
  - No report until two rises are seen.
  - Then `period` = 6.
- `en` dropped mid-period, then `rst` asserted mid-period.
  - Outputs hold, then clear to 0.
  - No `meas_valid`.
  - The first report after re-enable needs two fresh rises.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
//   Shared definitions for the period / high-time meter.
//   - state_t        : measurement FSM states
//   - DEF_CNT_W      : default counter / result width
//   - DEF_SYNC_STAGES: default synchroniser depth (must be >= 2)
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// sync_edge_det
//   Brings an asynchronous level into the clk domain and flags its edges.
//   Ports:
//     clk    in   clock
//     rst    in   synchronous active-high reset, clears every flop to 0
//     sig_in in   asynchronous input level
//     s      out  synchronised level, aligned with rise/fall
//     rise   out  one-cycle pulse on a 0->1 transition of the synchronised level
//     fall   out  one-cycle pulse on a 1->0 transition of the synchronised level
module sync_edge_det
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Edge pulses are registered; r_s_d carries the same sample as w_s one
    // cycle later, so the exported level lines up with the exported pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_s_d  <= w_s;
            r_rise <= w_s & ~r_s_d;
            r_fall <= ~w_s & r_s_d;
        end
    end

    assign s    = r_s_d;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule

// File: rtl/freq_meter.sv
// freq_meter
//   Measures the period and high time of a slow periodic signal in clk cycles.
//   Ports:
//     clk        in   sole clock, rising edge
//     rst        in   synchronous active-high reset
//     en         in   measurement enable; low returns the meter to IDLE
//     sig_in     in   measured signal, asynchronous to clk
//     period     out  clk cycles between the last two rising edges
//     high_time  out  clk cycles the signal was high in that period
//     meas_valid out  one-cycle pulse when period/high_time/overflow update
//     overflow   out  a counter saturated during the reported measurement
//     dbg_state  out  current FSM state (state_t encoding)
//   Handshake: meas_valid is a pure strobe with no back-pressure; the result
//   registers hold their value until the next strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic w_s;
    logic w_rise;
    logic w_fall;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .s      (w_s),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    state_t           r_state;
    state_t           w_next_state;
    logic             w_clear;
    logic             w_load;
    logic             w_report;
    logic             w_count;

    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic             r_sat;
    logic             r_fell;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // en is checked before rise everywhere, so a rise coinciding with en
    // dropping is discarded rather than reported.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_report     = 1'b0;
        w_count      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clear = 1'b1;
                if (en) w_next_state = ST_ARM;
            end
            ST_ARM: begin
                if (!en) begin
                    w_next_state = ST_IDLE;
                end else if (w_rise) begin
                    w_load       = 1'b1;
                    w_next_state = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (!en) begin
                    w_next_state = ST_IDLE;
                end else if (w_rise) begin
                    w_report = 1'b1;
                    w_load   = 1'b1;
                end else begin
                    w_count = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // sat marks that at least one count was dropped because a counter was
    // already at its maximum; a count that just reaches the maximum is exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt   <= '0;
            r_hcnt   <= '0;
            r_sat    <= 1'b0;
            r_fell   <= 1'b0;
            r_period <= '0;
            r_high   <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_valid <= w_report;
            if (w_report) begin
                r_period <= r_pcnt;
                r_high   <= r_hcnt;
                r_ovf    <= r_sat;
            end
            if (w_clear) begin
                r_pcnt <= '0;
                r_hcnt <= '0;
                r_sat  <= 1'b0;
                r_fell <= 1'b0;
            end else if (w_load) begin
                r_pcnt <= CNT_ONE;
                r_hcnt <= CNT_ONE;
                r_sat  <= 1'b0;
                r_fell <= 1'b0;
            end else if (w_count) begin
                if (r_pcnt == CNT_MAX) r_sat <= 1'b1;
                else                   r_pcnt <= r_pcnt + CNT_ONE;
                // High time stops at the first fall of the period.
                if (w_s && !r_fell) begin
                    if (r_hcnt == CNT_MAX) r_sat <= 1'b1;
                    else                   r_hcnt <= r_hcnt + CNT_ONE;
                end
                if (w_fall) r_fell <= 1'b1;
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high;
    assign meas_valid = r_valid;
    assign overflow   = r_ovf;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter
//   Drives two freq_meter instances (CNT_W = 16 and CNT_W = 4) with the same
//   stimulus and compares every cycle against a model that works on the list
//   of sig_in values sampled at each clock edge.
module tb_freq_meter;
    import freq_meter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic en;
    logic sig_in;

    always #5 clk = ~clk;

    logic [15:0] period_a, high_a;
    logic        valid_a, ovf_a;
    logic [1:0]  dbg_a;
    logic [3:0]  period_b, high_b;
    logic        valid_b, ovf_b;
    logic [1:0]  dbg_b;

    freq_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sig_in     (sig_in),
        .period     (period_a),
        .high_time  (high_a),
        .meas_valid (valid_a),
        .overflow   (ovf_a),
        .dbg_state  (dbg_a)
    );

    freq_meter #(.CNT_W(4), .SYNC_STAGES(2)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sig_in     (sig_in),
        .period     (period_b),
        .high_time  (high_b),
        .meas_valid (valid_b),
        .overflow   (ovf_b),
        .dbg_state  (dbg_b)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_reports = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A rise sampled at edge e is acted on at edge e+SYNC_STAGES+1 and shows
    // up on meas_valid after that edge (the SYNC_STAGES+2-th edge counting
    // the sampling edge as the first).
    localparam int LAT = 3;

    bit          samp_q[$];
    logic [31:0] exp_q[$];          // expected {high_time, period} of instance a
    int          edge_n   = -1;
    bit          armed    = 1'b0;   // enabled at the previous edge, so not IDLE
    int          start_e  = -1;     // sampling edge of the rise opening the period
    bit          exp_valid = 1'b0;
    int unsigned exp_p[2] = '{0, 0};
    int unsigned exp_h[2] = '{0, 0};
    bit          exp_o[2] = '{0, 0};
    int unsigned max_v[2] = '{65535, 15};

    function automatic int unsigned clamp(input int unsigned v, input int unsigned m);
        return (v > m) ? m : v;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            samp_q.push_back(sig_in);
            edge_n++;
            exp_valid = 1'b0;
            if (rst) begin
                // Reset empties the synchroniser: recent samples are forgotten.
                for (int k = 0; k < LAT; k++)
                    if (edge_n - k >= 0) samp_q[edge_n - k] = 1'b0;
                armed   = 1'b0;
                start_e = -1;
                for (int k = 0; k < 2; k++) begin
                    exp_p[k] = 0; exp_h[k] = 0; exp_o[k] = 1'b0;
                end
            end else if (!en) begin
                armed   = 1'b0;
                start_e = -1;
            end else begin
                if (armed && edge_n > LAT &&
                    samp_q[edge_n - LAT] && !samp_q[edge_n - LAT - 1]) begin
                    int e1;
                    e1 = edge_n - LAT;
                    if (start_e >= 0) begin
                        int unsigned raw_p, raw_h;
                        raw_p = e1 - start_e;
                        raw_h = raw_p;
                        for (int f = start_e + 1; f < e1; f++) begin
                            if (!samp_q[f]) begin
                                raw_h = f - start_e;
                                break;
                            end
                        end
                        for (int k = 0; k < 2; k++) begin
                            exp_p[k] = clamp(raw_p, max_v[k]);
                            exp_h[k] = clamp(raw_h, max_v[k]);
                            exp_o[k] = (raw_p > max_v[k]);
                        end
                        exp_valid = 1'b1;
                        exp_q.push_back({exp_h[0][15:0], exp_p[0][15:0]});
                    end
                    start_e = e1;
                end
                armed = 1'b1;
            end

            @(negedge clk);
            check("valid_a", valid_a, exp_valid);
            check("valid_b", valid_b, exp_valid);
            check("ovf_a", ovf_a, exp_o[0]);
            check("period_b", period_b, exp_p[1]);
            check("high_b", high_b, exp_h[1]);
            check("ovf_b", ovf_b, exp_o[1]);
            if (valid_a) begin
                n_reports++;
                if (exp_q.size() == 0) begin
                    check("report_a_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [31:0] w;
                    w = exp_q.pop_front();
                    check("period_a", period_a, w[15:0]);
                    check("high_a", high_a, w[31:16]);
                end
            end else begin
                check("period_a_hold", period_a, exp_p[0]);
                check("high_a_hold", high_a, exp_h[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic hold(input logic v, input int n);
        sig_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int hi, input int lo, input int reps);
        repeat (reps) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("dbg_state_reset_a", 32'(dbg_a), 32'(ST_IDLE));
        check("dbg_state_reset_b", 32'(dbg_b), 32'(ST_IDLE));
        rst = 1'b0;
        hold(1'b0, 2);

        // 1,0,0 repeating: period 3, high 1
        en = 1'b1;
        hold(1'b0, 2);
        pulse(1, 2, 8);

        // high 5, low 7: period 12, high 5
        pulse(5, 7, 4);

        // high 2, low 20: saturates the 4-bit meter, then a normal period
        pulse(2, 20, 3);
        pulse(3, 4, 3);

        // signal already high at enable
        en = 1'b0;
        hold(1'b1, 3);
        en = 1'b1;
        hold(1'b1, 10);
        hold(1'b0, 3);
        pulse(3, 3, 5);

        // enable dropped mid-period, then reset mid-period
        pulse(4, 6, 2);
        hold(1'b1, 2);
        en = 1'b0;
        hold(1'b1, 2);
        hold(1'b0, 4);
        en = 1'b1;
        pulse(4, 6, 3);
        hold(1'b1, 2);
        hold(1'b0, 3);
        rst = 1'b1;
        hold(1'b0, 2);
        rst = 1'b0;
        pulse(4, 6, 3);

        // randomized pulse trains with occasional enable drops
        repeat (60) begin
            pulse($urandom_range(1, 12), $urandom_range(1, 25), 1);
            if ($urandom_range(0, 9) == 0) begin
                en = 1'b0;
                hold(sig_in, $urandom_range(1, 5));
                en = 1'b1;
            end
        end

        hold(1'b0, 10);
        check("reports_seen", 32'(n_reports > 40), 32'd1);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
